// File: rtl/cv32e40x_pma_filter.sv
// PMA filter between core LSU/fetch and bus: blocks PMA-faulting accesses
// and answers them with an in-order error response once the bus drains.
module cv32e40x_pma_filter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_trans_valid_i,
  output logic        core_trans_ready_o,
  input  logic [31:0] core_trans_addr_i,
  input  logic        core_trans_we_i,
  input  logic        pma_err_i,
  input  logic        pma_bufferable_i,
  output logic        bus_trans_valid_o,
  input  logic        bus_trans_ready_i,
  output logic [31:0] bus_trans_addr_o,
  output logic        bus_trans_we_o,
  output logic        bus_trans_bufferable_o,
  input  logic        bus_resp_valid_i,
  input  logic [31:0] bus_resp_rdata_i,
  input  logic        bus_resp_err_i,
  output logic        core_resp_valid_o,
  output logic [31:0] core_resp_rdata_o,
  output logic        core_resp_err_o,
  output logic        core_resp_pma_err_o
);

  typedef enum logic {IDLE, ERR_RESP} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  state_t     state;
  logic [2:0] cnt;
  logic       room;
  logic       empty;
  logic       bus_hs;
  logic       blk_acc;

  assign room  = cnt < MAX_CNT;
  assign empty = cnt == 3'd0;

  assign bus_trans_addr_o       = core_trans_addr_i;
  assign bus_trans_we_o         = core_trans_we_i;
  assign bus_trans_bufferable_o = pma_bufferable_i;

  always_comb begin
    bus_trans_valid_o   = 1'b0;
    core_trans_ready_o  = 1'b0;
    core_resp_valid_o   = 1'b0;
    core_resp_rdata_o   = 32'h0;
    core_resp_err_o     = 1'b0;
    core_resp_pma_err_o = 1'b0;
    unique case (state)
      IDLE: begin
        core_resp_valid_o = bus_resp_valid_i;
        core_resp_rdata_o = bus_resp_rdata_i;
        core_resp_err_o   = bus_resp_err_i;
        // Blocked access waits for the bus to drain to keep order
        unique case (1'b1)
          pma_err_i: begin
            core_trans_ready_o = empty;
          end
          default: begin
            bus_trans_valid_o  = core_trans_valid_i && room;
            core_trans_ready_o = bus_trans_ready_i && room;
          end
        endcase
      end
      ERR_RESP: begin
        core_resp_valid_o   = 1'b1;
        core_resp_err_o     = 1'b1;
        core_resp_pma_err_o = 1'b1;
      end
    endcase
  end

  assign bus_hs  = bus_trans_valid_o && bus_trans_ready_i;
  assign blk_acc = (state == IDLE) && pma_err_i &&
                   core_trans_valid_i && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= blk_acc ? ERR_RESP : IDLE;
      unique case ({bus_hs, bus_resp_valid_i})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= empty ? cnt : cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_resp_outstanding: assert property (
    @(posedge clk) disable iff (rst)
    bus_resp_valid_i |-> !empty
  ) else $error("bus response with no transaction outstanding");

  a_resp_in_err: assert property (
    @(posedge clk) disable iff (rst)
    (state == ERR_RESP) |-> !bus_resp_valid_i
  ) else $error("bus response during error response slot");

endmodule
